// File: rtl/datapath_unit.sv
// Single-bus 32-bit CPU datapath slice driven by one-hot control strobes.
// Optional BusConflict output is enabled by defining BUS_CONFLICT_DETECT_EN.
module datapath_unit #(
  parameter int WIDTH = 32
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               PCout,
  input  logic               Zlowout,
  input  logic               MDRout,
  input  logic               R2out,
  input  logic               R4out,
  input  logic               MARin,
  input  logic               Zin,
  input  logic               PCin,
  input  logic               MDRin,
  input  logic               IRin,
  input  logic               Yin,
  input  logic               IncPC,
  input  logic               Read,
  input  logic               AND,
  input  logic               R5in,
  input  logic               R2in,
  input  logic               R4in,
  input  logic [WIDTH-1:0]   Mdatain,
  output logic [WIDTH-1:0]   BusMuxOut,
  output logic [WIDTH-1:0]   PC_q,
  output logic [WIDTH-1:0]   IR_q,
  output logic [WIDTH-1:0]   MAR_q,
  output logic [WIDTH-1:0]   MDR_q,
  output logic [WIDTH-1:0]   Y_q,
  output logic [WIDTH-1:0]   R2_q,
  output logic [WIDTH-1:0]   R4_q,
  output logic [WIDTH-1:0]   R5_q,
  output logic [2*WIDTH-1:0] Z_q
`ifdef BUS_CONFLICT_DETECT_EN
  ,
  output logic               BusConflict
`endif
);

  logic [WIDTH-1:0]   pc_reg, ir_reg, mar_reg, mdr_reg, y_reg;
  logic [2*WIDTH-1:0] z_reg, z_next;
  logic [WIDTH-1:0]   mdr_next;
  logic [2:0]         gp_load;
  logic [2:0][WIDTH-1:0] gp_q;

  always_comb begin
    if (MDRout)       BusMuxOut = mdr_reg;
    else if (Zlowout) BusMuxOut = z_reg[WIDTH-1:0];
    else if (PCout)   BusMuxOut = pc_reg;
    else if (R2out)   BusMuxOut = gp_q[0];
    else if (R4out)   BusMuxOut = gp_q[1];
    else              BusMuxOut = '0;
  end

  // The increment is WIDTH bits wide so it wraps without carrying into Zhigh.
  always_comb begin
    if (AND)        z_next = {{WIDTH{1'b0}}, y_reg & BusMuxOut};
    else if (IncPC) z_next = {{WIDTH{1'b0}}, BusMuxOut + {{(WIDTH-1){1'b0}}, 1'b1}};
    else            z_next = '0;
  end

  assign mdr_next = Read ? Mdatain : BusMuxOut;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pc_reg  <= '0;
      ir_reg  <= '0;
      mar_reg <= '0;
      mdr_reg <= '0;
      y_reg   <= '0;
      z_reg   <= '0;
    end else begin
      if (PCin)  pc_reg  <= BusMuxOut;
      if (IRin)  ir_reg  <= BusMuxOut;
      if (MARin) mar_reg <= BusMuxOut;
      if (MDRin) mdr_reg <= mdr_next;
      if (Yin)   y_reg   <= BusMuxOut;
      if (Zin)   z_reg   <= z_next;
    end
  end

  // General registers: index 0 = R2, 1 = R4, 2 = R5.
  assign gp_load = {R5in, R4in, R2in};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_gp
      logic [WIDTH-1:0] q_reg;
      always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)          q_reg <= '0;
        else if (gp_load[gi]) q_reg <= BusMuxOut;
      end
      assign gp_q[gi] = q_reg;
    end
  endgenerate

  assign PC_q  = pc_reg;
  assign IR_q  = ir_reg;
  assign MAR_q = mar_reg;
  assign MDR_q = mdr_reg;
  assign Y_q   = y_reg;
  assign Z_q   = z_reg;
  assign R2_q  = gp_q[0];
  assign R4_q  = gp_q[1];
  assign R5_q  = gp_q[2];

`ifdef BUS_CONFLICT_DETECT_EN
  logic [4:0] out_sel;
  assign out_sel     = {R4out, R2out, PCout, Zlowout, MDRout};
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign BusConflict = |(out_sel & (out_sel - 5'd1));
`endif

endmodule

// File: tb/tb_datapath_unit.sv
// Bench for datapath_unit: directed vector table, hand sequences, random vs model.
// Also checks BusConflict when BUS_CONFLICT_DETECT_EN is defined.
module tb_datapath_unit;

  localparam int I_PCO = 0, I_ZLO = 1, I_MDRO = 2, I_R2O = 3, I_R4O = 4;
  localparam int I_MARI = 5, I_ZI = 6, I_PCI = 7, I_MDRI = 8, I_IRI = 9;
  localparam int I_YI = 10, I_INC = 11, I_RD = 12, I_AND = 13;
  localparam int I_R5I = 14, I_R2I = 15, I_R4I = 16;

  localparam logic [16:0] PCO = 17'd1 << I_PCO, ZLO = 17'd1 << I_ZLO, MDRO = 17'd1 << I_MDRO;
  localparam logic [16:0] R2O = 17'd1 << I_R2O, R4O = 17'd1 << I_R4O, MARI = 17'd1 << I_MARI;
  localparam logic [16:0] ZI = 17'd1 << I_ZI, PCI = 17'd1 << I_PCI, MDRI = 17'd1 << I_MDRI;
  localparam logic [16:0] IRI = 17'd1 << I_IRI, YI = 17'd1 << I_YI, INC = 17'd1 << I_INC;
  localparam logic [16:0] RD = 17'd1 << I_RD, ANDS = 17'd1 << I_AND, R5I = 17'd1 << I_R5I;
  localparam logic [16:0] R2I = 17'd1 << I_R2I, R4I = 17'd1 << I_R4I;

  // Output selectors for checks: 0 PC,1 IR,2 MAR,3 MDR,4 Y,5 R2,6 R4,7 R5,8 Z
  localparam int K_PC = 0, K_IR = 1, K_MAR = 2, K_MDR = 3, K_Y = 4;
  localparam int K_R2 = 5, K_R4 = 6, K_R5 = 7, K_Z = 8;

  logic Clock, Resetn;
  logic PCout, Zlowout, MDRout, R2out, R4out, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic IncPC, Read, AND, R5in, R2in, R4in;
  logic [31:0] Mdatain, BusMuxOut, PC_q, IR_q, MAR_q, MDR_q, Y_q, R2_q, R4_q, R5_q;
  logic [63:0] Z_q;
`ifdef BUS_CONFLICT_DETECT_EN
  logic BusConflict;
`endif

  datapath_unit #(.WIDTH(32)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .R2out(R2out), .R4out(R4out),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .AND(AND), .R5in(R5in), .R2in(R2in), .R4in(R4in),
    .Mdatain(Mdatain), .BusMuxOut(BusMuxOut),
    .PC_q(PC_q), .IR_q(IR_q), .MAR_q(MAR_q), .MDR_q(MDR_q), .Y_q(Y_q),
    .R2_q(R2_q), .R4_q(R4_q), .R5_q(R5_q), .Z_q(Z_q)
`ifdef BUS_CONFLICT_DETECT_EN
    , .BusConflict(BusConflict)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: architectural registers by name index, Z separately.
  logic [31:0] m_reg [8];
  logic [63:0] m_z;
  string reg_name [9] = '{"PC", "IR", "MAR", "MDR", "Y", "R2", "R4", "R5", "Z"};

  typedef struct {
    logic [16:0] c;
    logic [31:0] md;
    int          k1;
    logic [63:0] e1;
    int          k2;
    logic [63:0] e2;
  } vec_t;
  vec_t tbl [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] get_q(input int k);
    case (k)
      K_PC:    return {32'h0, PC_q};
      K_IR:    return {32'h0, IR_q};
      K_MAR:   return {32'h0, MAR_q};
      K_MDR:   return {32'h0, MDR_q};
      K_Y:     return {32'h0, Y_q};
      K_R2:    return {32'h0, R2_q};
      K_R4:    return {32'h0, R4_q};
      K_R5:    return {32'h0, R5_q};
      default: return Z_q;
    endcase
  endfunction

  function automatic logic [63:0] model_q(input int k);
    if (k == K_Z) return m_z;
    return {32'h0, m_reg[k]};
  endfunction

  // Bus sources listed in priority order; the first selected one wins.
  function automatic logic [31:0] model_bus(input logic [16:0] c);
    int          sel_bit [5] = '{I_MDRO, I_ZLO, I_PCO, I_R2O, I_R4O};
    logic [31:0] src     [5];
    src = '{m_reg[K_MDR], m_z[31:0], m_reg[K_PC], m_reg[K_R2], m_reg[K_R4]};
    for (int i = 0; i < 5; i++)
      if (c[sel_bit[i]]) return src[i];
    return 32'h0;
  endfunction

  task automatic drive(input logic [16:0] c, input logic [31:0] md);
    PCout = c[I_PCO];  Zlowout = c[I_ZLO]; MDRout = c[I_MDRO]; R2out = c[I_R2O];
    R4out = c[I_R4O];  MARin = c[I_MARI];  Zin = c[I_ZI];      PCin = c[I_PCI];
    MDRin = c[I_MDRI]; IRin = c[I_IRI];    Yin = c[I_YI];      IncPC = c[I_INC];
    Read = c[I_RD];    AND = c[I_AND];     R5in = c[I_R5I];    R2in = c[I_R2I];
    R4in = c[I_R4I];   Mdatain = md;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
    m_z = 64'h0;
  endtask

  // Called just after a rising edge; leaves time at the next edge + 1.
  task automatic step(input logic [16:0] c, input logic [31:0] md);
    logic [31:0] b;
    logic [63:0] alu;
    drive(c, md);
    #1;
    b = model_bus(c);
    check("bus", {32'h0, BusMuxOut}, {32'h0, b});
`ifdef BUS_CONFLICT_DETECT_EN
    check("conflict", {63'h0, BusConflict}, {63'h0, ($countones(c[4:0]) > 1)});
`endif
    if (c[I_AND])      alu = {32'h0, m_reg[K_Y] & b};
    else if (c[I_INC]) alu = {32'h0, b + 32'd1};
    else               alu = 64'h0;
    @(posedge Clock);
    if (c[I_PCI])  m_reg[K_PC]  = b;
    if (c[I_IRI])  m_reg[K_IR]  = b;
    if (c[I_MARI]) m_reg[K_MAR] = b;
    if (c[I_MDRI]) m_reg[K_MDR] = c[I_RD] ? md : b;
    if (c[I_YI])   m_reg[K_Y]   = b;
    if (c[I_R2I])  m_reg[K_R2]  = b;
    if (c[I_R4I])  m_reg[K_R4]  = b;
    if (c[I_R5I])  m_reg[K_R5]  = b;
    if (c[I_ZI])   m_z          = alu;
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 9; k++)
      check({tag, "_", reg_name[k]}, get_q(k), model_q(k));
  endtask

  initial begin
    // Reset with every strobe high must still leave everything at zero.
    Resetn = 1'b0;
    drive(17'h1FFFF, 32'hDEADBEEF);
    model_reset();
    repeat (3) @(posedge Clock);
    #1;
    for (int k = 0; k < 9; k++) check({"reset_", reg_name[k]}, get_q(k), 64'h0);
    drive(17'h0, 32'h0);
    #2;
    Resetn = 1'b1;
    @(posedge Clock);
    #1;

    tbl[0]  = '{RD | MDRI, 32'h22, K_MDR, 64'h22, -1, 64'h0};
    tbl[1]  = '{MDRO | R2I, 32'h0, K_R2, 64'h22, -1, 64'h0};
    tbl[2]  = '{RD | MDRI, 32'h24, K_MDR, 64'h24, -1, 64'h0};
    tbl[3]  = '{MDRO | R4I, 32'h0, K_R4, 64'h24, -1, 64'h0};
    tbl[4]  = '{RD | MDRI, 32'h26, K_MDR, 64'h26, -1, 64'h0};
    tbl[5]  = '{MDRO | R5I, 32'h0, K_R5, 64'h26, -1, 64'h0};
    tbl[6]  = '{PCO | MARI | INC | ZI, 32'h0, K_MAR, 64'h0, K_Z, 64'h1};
    tbl[7]  = '{ZLO | PCI | RD | MDRI, 32'h4A920000, K_PC, 64'h1, K_MDR, 64'h4A920000};
    tbl[8]  = '{MDRO | IRI, 32'h0, K_IR, 64'h4A920000, -1, 64'h0};
    tbl[9]  = '{R2O | YI, 32'h0, K_Y, 64'h22, -1, 64'h0};
    tbl[10] = '{R4O | ANDS | ZI, 32'h0, K_Z, 64'h20, -1, 64'h0};
    tbl[11] = '{ZLO | R5I, 32'h0, K_R5, 64'h20, -1, 64'h0};
    tbl[12] = '{R2O | R2I, 32'h0, K_R2, 64'h22, -1, 64'h0};

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].c, tbl[i].md);
      check($sformatf("vec%0d_%s", i, reg_name[tbl[i].k1]), get_q(tbl[i].k1), tbl[i].e1);
      if (tbl[i].k2 >= 0)
        check($sformatf("vec%0d_%s", i, reg_name[tbl[i].k2]), get_q(tbl[i].k2), tbl[i].e2);
    end

    // PC increment wraps at all-ones with nothing carried into Zhigh.
    step(RD | MDRI, 32'hFFFFFFFF);
    step(MDRO | PCI, 32'h0);
    check("wrap_pc", get_q(K_PC), 64'hFFFFFFFF);
    step(PCO | INC | ZI, 32'h0);
    check("wrap_z", Z_q, 64'h0);

    // AND takes precedence over IncPC: Y=0x22, R4=0x24.
    step(R4O | ANDS | INC | ZI, 32'h0);
    check("and_over_inc", Z_q, 64'h20);

    // MDR wins over PC on the bus.
    step(RD | MDRI, 32'h12345678);
    drive(MDRO | PCO, 32'h0);
    #1;
    check("prio_bus", {32'h0, BusMuxOut}, 64'h12345678);
`ifdef BUS_CONFLICT_DETECT_EN
    check("prio_conflict", {63'h0, BusConflict}, 64'h1);
`endif
    drive(17'h0, 32'h0);
    #1;
    check("idle_bus", {32'h0, BusMuxOut}, 64'h0);
    @(posedge Clock);
    #1;

    // Async reset in the middle of the AND sequence, between edges.
    step(R2O | YI, 32'h0);
    check("mid_y", get_q(K_Y), 64'h12345678 & 64'h0 | {32'h0, m_reg[K_Y]});
    drive(R4O | ANDS | ZI, 32'h0);
    #1;
    Resetn = 1'b0;
    #1;
    model_reset();
    check_all("async");
    #1;
    Resetn = 1'b1;
    drive(17'h0, 32'h0);
    @(posedge Clock);
    #1;
    check_all("post_rel");
    step(RD | MDRI, 32'h55);
    check("first_load", get_q(K_MDR), 64'h55);

    // Random strobes against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [16:0] c;
      c = 17'($urandom);
      if (n % 3 == 0) c[4:0] = 5'd1 << $urandom_range(0, 4);
      step(c, $urandom);
      check_all($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
